fetch_unit: RTL and testbench

- First pipeline stage: owns the program counter, fetches instruction words from instruction memory over a req/ack handshake, and registers them as `instruction` for the read stage.
- Inserts NOP bubbles on memory wait cycles and jump flushes.
- Freezes its output while `halt` is asserted.
- Accepts PC redirects (absolute jump target) from the execute stage.

---
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// First pipeline stage: program counter, instruction-memory req/ack fetch, one-entry skid
// buffer for halts, and jump redirects. Optional FETCH_COUNTERS_EN adds fetch/stall counters.
module fetch_unit #(
   parameter int ADDR_SIZE        = 10,
   parameter int INSTRUCTION_SIZE = 16,
   parameter logic [ADDR_SIZE-1:0]        RESET_PC = '0,
   parameter logic [INSTRUCTION_SIZE-1:0] NOP_WORD = '0
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        halt,
   input  logic                        jump_valid,
   input  logic [ADDR_SIZE-1:0]        jump_address,
   output logic                        imem_req,
   output logic [ADDR_SIZE-1:0]        imem_address,
   input  logic                        imem_ack,
   input  logic [INSTRUCTION_SIZE-1:0] imem_rdata,
   output logic [INSTRUCTION_SIZE-1:0] instruction,
   output logic [ADDR_SIZE-1:0]        pc_out
`ifdef FETCH_COUNTERS_EN
   ,
   output logic [31:0]                 fetch_count,
   output logic [31:0]                 stall_count
`endif
);

   typedef enum logic [1:0] {IDLE, REQ, BUFFERED, DROP} state_t;

   state_t                      state;
   logic [ADDR_SIZE-1:0]        pc;
   logic [ADDR_SIZE-1:0]        drop_address;
   logic [ADDR_SIZE-1:0]        buffer_pc;
   logic [INSTRUCTION_SIZE-1:0] buffer_word;
   logic                        bubble;

   // The skid buffer holds a word exactly when state is BUFFERED, so no separate valid bit.
   assign imem_req     = (state == REQ) || (state == DROP);
   assign imem_address = (state == DROP) ? drop_address : pc;

   always_comb begin
      bubble = !halt && (jump_valid || state == DROP || (state == REQ && !imem_ack));
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         pc           <= RESET_PC;
         pc_out       <= '0;
         instruction  <= NOP_WORD;
         drop_address <= '0;
         buffer_pc    <= '0;
         buffer_word  <= NOP_WORD;
      end else begin
         if (bubble)
            instruction <= NOP_WORD;
         case (state)
            IDLE: begin
               if (jump_valid)
                  pc <= jump_address;
               state <= REQ;
            end
            REQ: begin
               if (jump_valid) begin
                  pc <= jump_address;
                  // An unacked request cannot be withdrawn; keep presenting it and discard its data.
                  if (!imem_ack) begin
                     drop_address <= pc;
                     state        <= DROP;
                  end
               end else if (imem_ack) begin
                  pc <= pc + ADDR_SIZE'(1);
                  if (halt) begin
                     buffer_word <= imem_rdata;
                     buffer_pc   <= pc;
                     state       <= BUFFERED;
                  end else begin
                     instruction <= imem_rdata;
                     pc_out      <= pc;
                  end
               end
            end
            BUFFERED: begin
               if (jump_valid) begin
                  pc    <= jump_address;
                  state <= REQ;
               end else if (!halt) begin
                  instruction <= buffer_word;
                  pc_out      <= buffer_pc;
                  state       <= REQ;
               end
            end
            DROP: begin
               if (jump_valid)
                  pc <= jump_address;
               if (imem_ack)
                  state <= REQ;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FETCH_COUNTERS_EN
   logic present;

   always_comb begin
      present = !jump_valid && !halt && ((state == REQ && imem_ack) || state == BUFFERED);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_count <= '0;
         stall_count <= '0;
      end else begin
         if (present)
            fetch_count <= fetch_count + 32'd1;
         if (halt || bubble)
            stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed literal checks plus randomized traffic against a
// queue-based fetch-stream model compared on every falling edge.
module tb_fetch_unit;
   localparam int A = 10;
   localparam int W = 16;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         halt = 1'b0;
   logic         jump_valid = 1'b0;
   logic [A-1:0] jump_address = '0;
   logic         imem_ack = 1'b0;
   logic [W-1:0] imem_rdata = '0;
   logic         imem_req;
   logic [A-1:0] imem_address;
   logic [W-1:0] instruction;
   logic [A-1:0] pc_out;
`ifdef FETCH_COUNTERS_EN
   logic [31:0]  fetch_count;
   logic [31:0]  stall_count;
`endif

   int tests = 0;
   int fails = 0;

   fetch_unit #(.ADDR_SIZE(A), .INSTRUCTION_SIZE(W), .RESET_PC('0), .NOP_WORD('0)) dut (
      .clock(clock), .reset(reset), .halt(halt), .jump_valid(jump_valid),
      .jump_address(jump_address), .imem_req(imem_req), .imem_address(imem_address),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction(instruction),
      .pc_out(pc_out)
`ifdef FETCH_COUNTERS_EN
      , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
   );

   always #5 clock = ~clock;

   function automatic logic [W-1:0] mem_word(input logic [A-1:0] a);
      return W'(a) + 16'h0100;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: stream of fetched words ----------------
   typedef struct {
      logic [W-1:0] word;
      logic [A-1:0] pc;
   } entry_t;

   entry_t       held[$];
   logic [A-1:0] m_pc, m_stale_addr, m_pc_out;
   logic [W-1:0] m_instr;
   bit           m_started, m_stale;
   logic [31:0]  m_fetch, m_stall;

   always @(posedge clock or negedge reset) begin : model
      bit req_now;
      bit bub;
      if (!reset) begin
         held.delete();
         m_pc = '0; m_stale_addr = '0; m_pc_out = '0; m_instr = '0;
         m_started = 0; m_stale = 0; m_fetch = 0; m_stall = 0;
      end else begin
         req_now = m_started && held.size() == 0;
         bub = 0;
         if (!m_started) begin
            if (jump_valid) begin m_pc = jump_address; bub = !halt; end
            m_started = 1;
         end else if (jump_valid) begin
            if (req_now && imem_ack) m_stale = 0;
            else if (req_now && !m_stale) begin m_stale = 1; m_stale_addr = m_pc; end
            held.delete();
            m_pc = jump_address;
            bub = !halt;
         end else if (held.size() != 0) begin
            if (!halt) begin
               m_instr = held[0].word; m_pc_out = held[0].pc; m_fetch++;
               held.delete();
            end
         end else if (m_stale) begin
            if (imem_ack) m_stale = 0;
            bub = !halt;
         end else if (imem_ack) begin
            if (halt) held.push_back('{mem_word(m_pc), m_pc});
            else begin m_instr = mem_word(m_pc); m_pc_out = m_pc; m_fetch++; end
            m_pc = m_pc + A'(1);
         end else begin
            bub = !halt;
         end
         if (bub) m_instr = '0;
         if (halt || bub) m_stall++;
      end
   end

   always @(negedge clock) begin
      if (reset) begin
         check("instruction", 32'(instruction), 32'(m_instr));
         check("pc_out", 32'(pc_out), 32'(m_pc_out));
         check("imem_req", 32'(imem_req), 32'(m_started && held.size() == 0));
         if (m_started && held.size() == 0)
            check("imem_address", 32'(imem_address), 32'(m_stale ? m_stale_addr : m_pc));
`ifdef FETCH_COUNTERS_EN
         check("fetch_count", fetch_count, m_fetch);
         check("stall_count", stall_count, m_stall);
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input bit h, input bit jv, input logic [A-1:0] ja, input bit ack);
      halt = h; jump_valid = jv; jump_address = ja;
      imem_ack = ack && imem_req;
      imem_rdata = imem_ack ? mem_word(imem_address) : W'($urandom);
      @(negedge clock);
   endtask

   task automatic do_reset();
      #2 reset = 1'b0;
      #1;
      check("rst_instruction", 32'(instruction), 32'h0);
      check("rst_pc_out", 32'(pc_out), 32'h0);
      check("rst_imem_req", 32'(imem_req), 32'h0);
`ifdef FETCH_COUNTERS_EN
      check("rst_fetch_count", fetch_count, 32'h0);
      check("rst_stall_count", stall_count, 32'h0);
`endif
      halt = 0; jump_valid = 0; imem_ack = 0;
      @(negedge clock);
      reset = 1'b1;
      step(0, 0, '0, 0);
   endtask

   initial begin : main
      int wait_cnt;
      int max_wait;
      bit ack;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      check("req_at_release", 32'(imem_req), 32'h0);
      step(0, 0, '0, 0);
      check("req_after_release", 32'(imem_req), 32'h1);
      check("addr_after_release", 32'(imem_address), 32'h0);
      for (int k = 0; k < 3; k++) begin
         step(0, 0, '0, 1);
         check("zw_instruction", 32'(instruction), 32'h0100 + 32'(k));
         check("zw_pc_out", 32'(pc_out), 32'(k));
      end
      // Two wait cycles per word: NOP, NOP, word.
      for (int k = 0; k < 3; k++) begin
         step(0, 0, '0, 0);
         check("w2_nop1", 32'(instruction), 32'h0);
         step(0, 0, '0, 0);
         check("w2_nop2", 32'(instruction), 32'h0);
         step(0, 0, '0, 1);
         check("w2_word", 32'(instruction), 32'h0103 + 32'(k));
         check("w2_pc_out", 32'(pc_out), 32'(3 + k));
      end

      // Halt with an ack for address 5 arriving while halted.
      do_reset();
      for (int k = 0; k < 5; k++) step(0, 0, '0, 1);
      check("pre_halt_addr", 32'(imem_address), 32'h5);
      step(1, 0, '0, 0); check("halt_frozen", 32'(instruction), 32'h0104);
      step(1, 0, '0, 1); check("halt_frozen", 32'(instruction), 32'h0104);
      check("halt_pc_out_frozen", 32'(pc_out), 32'h4);
      step(1, 0, '0, 0); check("halt_frozen", 32'(instruction), 32'h0104);
      step(1, 0, '0, 0); check("halt_frozen", 32'(instruction), 32'h0104);
      step(0, 0, '0, 0);
      check("unhalt_instruction", 32'(instruction), 32'h0105);
      check("unhalt_pc_out", 32'(pc_out), 32'h5);
      check("unhalt_req", 32'(imem_req), 32'h1);
      check("unhalt_addr", 32'(imem_address), 32'h6);

      // Jump while the request for address 7 is outstanding.
      step(0, 0, '0, 1);
      check("pre_jump_addr", 32'(imem_address), 32'h7);
      step(0, 1, 10'h3F0, 0);
      check("jump_nop", 32'(instruction), 32'h0);
      check("jump_pc_out_hold", 32'(pc_out), 32'h6);
      check("drop_addr", 32'(imem_address), 32'h7);
      step(0, 0, '0, 0);
      check("drop_addr2", 32'(imem_address), 32'h7);
      check("drop_nop", 32'(instruction), 32'h0);
      step(0, 0, '0, 1);
      check("drop_discard", 32'(instruction), 32'h0);
      check("redirect_addr", 32'(imem_address), 32'h3F0);
      step(0, 0, '0, 1);
      check("target_word", 32'(instruction), 32'h04F0);
      check("target_pc_out", 32'(pc_out), 32'h3F0);

      // PC wrap, with jump and ack in the same cycle.
      step(0, 1, 10'h3FF, 1);
      check("jump_ack_nop", 32'(instruction), 32'h0);
      check("wrap_addr", 32'(imem_address), 32'h3FF);
      step(0, 0, '0, 1);
      check("wrap_pc_3ff", 32'(pc_out), 32'h3FF);
      step(0, 0, '0, 1);
      check("wrap_pc_000", 32'(pc_out), 32'h0);
      check("wrap_word", 32'(instruction), 32'h0100);

      // Reset mid-request (address 1 outstanding), then counters.
      do_reset();
`ifdef FETCH_COUNTERS_EN
      step(0, 0, '0, 1); step(0, 0, '0, 1); step(0, 0, '0, 0); step(0, 0, '0, 1);
      step(0, 0, '0, 0); step(0, 0, '0, 1); step(0, 0, '0, 0); step(0, 0, '0, 1);
      check("cnt_fetch", fetch_count, 32'd5);
      check("cnt_stall", stall_count, 32'd3);
`endif

      // Randomized traffic: variable memory latency, halts and jumps.
      wait_cnt = 0;
      for (int k = 0; k < 4000; k++) begin
         if (k % 500 == 0) max_wait = $urandom_range(0, 3);
         ack = 0;
         if (imem_req) begin
            if (wait_cnt == 0) begin ack = 1; wait_cnt = $urandom_range(0, max_wait); end
            else wait_cnt--;
         end
         step(($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 6),
              ($urandom_range(0, 3) == 0) ? A'(10'h3FE + A'($urandom_range(0, 1))) : A'($urandom),
              ack);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
